telemetry_sched: RTL and testbench
==================================

# telemetry_sched

Periodic telemetry scheduler for the eBike. On every telemetry period tick it snapshots battery voltage, average motor current and average pedal torque. It then sequences an 8-byte framed packet through the existing UART transmitter, one byte at a time, using the transmitter's trmt/tx_done handshake. It sits in eBike between the sensor/averaging datapath and UART_tx, whose serial output drives the TX pin.

## Interface
- FAST_SIM, default 1: when 1, the period is 2^12 clk; when 0, the period is 2^20 clk.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- en  in  1  telemetry enable, sampled at each period tick.
- batt  in  12  battery voltage (A2D counts).
- curr  in  12  averaged motor current.
- torque  in  12  averaged pedal torque.
- tx_done  in  1  one-cycle pulse from UART_tx when a byte has finished shifting.
- trmt  out  1  one-cycle pulse that starts a UART_tx byte.
- tx_data  out  8  byte presented to UART_tx.
- busy  out  1  high while a packet is in flight.
- pkt_done  out  1  one-cycle pulse after the 8th byte's tx_done.
- ovr  out  1  sticky overrun flag; cleared only by reset.

## Operation
- Period counter:
  - Free-running, width 20 (FAST_SIM=0) or 12 (FAST_SIM=1).
  - Tick when the counter is all-ones; the counter wraps to 0.
  - The counter never stalls.
- Packet order:
  - Byte 0 = 0xAA, byte 1 = 0x55.
  - Byte 2 = {4'h0, batt[11:8]}, byte 3 = batt[7:0].
  - Byte 4 = {4'h0, curr[11:8]}, byte 5 = curr[7:0].
  - Byte 6 = {4'h0, torque[11:8]}, byte 7 = torque[7:0].
- Snapshot: batt, curr and torque are registered on the tick that starts a packet. Later input changes do not affect the packet in flight.
- FSM states: IDLE, LOAD, WAIT. A 3-bit byte index selects the byte.
  - IDLE: on tick with en=1, snapshot the inputs, set idx=0, go to LOAD. Tick with en=0 is ignored.
  - LOAD: assert trmt for one cycle, drive tx_data=byte[idx], go to WAIT.
  - WAIT: on tx_done with idx<7, increment idx and go to LOAD. On tx_done with idx==7, pulse pkt_done and go to IDLE.
- Overrun: a tick while busy=1 sets ovr. That tick is discarded; the packet in flight completes unchanged.
- tx_done while in IDLE or LOAD is ignored.
- Reset mid-packet: on the next edge, trmt=0, busy=0, the FSM is in IDLE and the counter is 0. No partial packet resumes.

## Timing
- Reset values:
  - trmt=0, tx_data=8'h00, busy=0, pkt_done=0, ovr=0.
  - Counter 0, idx 0, snapshot registers 0.
- Tick to first trmt: trmt is high exactly 1 cycle after the tick cycle (the LOAD cycle).
- tx_done to next trmt: 1 cycle after tx_done is sampled.
- tx_data is registered and set in LOAD. It holds stable from the trmt cycle until the tx_done that ends that byte.
- busy:
  - Rises in the cycle after the starting tick.
  - Falls in the same cycle pkt_done is high.
  - A tick in that same cycle counts as idle: it starts a new packet and does not set ovr.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package eBike_pkg holds:
  - Enum telem_state_t {IDLE, LOAD, WAIT}.
  - Localparams TELEM_HDR0=8'hAA, TELEM_HDR1=8'h55, TELEM_NBYTES=8.
  - Localparams TELEM_PER_W_FAST=12, TELEM_PER_W=20.
- One sub-module, telem_period_tmr: FAST_SIM-parameterised free-running counter with a tick output and synchronous active-low reset.
- UART_tx stays outside this block; eBike wires trmt, tx_data and tx_done between the two.

## Test plan
- Basic packet:
  - Stimulus: FAST_SIM=1, en=1, batt=0xB80, curr=0x123, torque=0x700; tx_done pulsed 10 cycles after each trmt.
  - Response: bytes AA 55 0B 80 01 23 07 00; pkt_done fires once; busy low afterwards; next packet starts at tick 4096 clk later.
- Snapshot: change batt to 0x400 after byte 2 is sent -> byte 3 is still 0x80; the next packet carries 04 00.
- Disable: hold en=0 across 3 ticks -> trmt never asserts, busy=0, ovr=0.
- Overrun: withhold tx_done for more than 4096 cycles -> ovr=1 after the next tick; the current packet completes all 8 bytes; no second packet until the following idle tick.
- Reset mid-packet: assert rst_n=0 during byte 4's WAIT -> the next edge gives trmt=0, busy=0, tx_data=0x00; after release, the first packet begins with 0xAA.
- Spurious tx_done: pulse tx_done in IDLE -> no trmt and no state change; the next tick sends a normal packet.

Source files
------------

// File: rtl/telemetry_sched_pkg.sv
// Shared types and constants for the eBike telemetry scheduler.
//   telem_state_t : scheduler FSM states (IDLE, LOAD, WAIT)
//   TELEM_*       : packet header bytes, packet length, period widths
//   telem_byte()  : maps a byte index and snapshot values to a packet byte
package eBike_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } telem_state_t;

    localparam logic [7:0]  TELEM_HDR0       = 8'hAA;
    localparam logic [7:0]  TELEM_HDR1       = 8'h55;
    localparam int unsigned TELEM_NBYTES     = 8;
    localparam int unsigned TELEM_PER_W_FAST = 12;
    localparam int unsigned TELEM_PER_W      = 20;

    // Packet layout: header, then each 12-bit value as high nibble / low byte.
    function automatic logic [7:0] telem_byte(
        input logic [2:0]  idx,
        input logic [11:0] batt,
        input logic [11:0] curr,
        input logic [11:0] torque
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = TELEM_HDR0;
            3'd1:    b = TELEM_HDR1;
            3'd2:    b = {4'h0, batt[11:8]};
            3'd3:    b = batt[7:0];
            3'd4:    b = {4'h0, curr[11:8]};
            3'd5:    b = curr[7:0];
            3'd6:    b = {4'h0, torque[11:8]};
            default: b = torque[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/telemetry_sched_if.sv
// Byte handshake between the telemetry scheduler and UART_tx.
//   trmt    : one-cycle pulse starting a byte (scheduler -> UART)
//   tx_data : byte to transmit (scheduler -> UART)
//   tx_done : one-cycle pulse when the byte has shifted out (UART -> scheduler)
// master = scheduler side, slave = transmitter side.
interface telemetry_sched_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output trmt, output tx_data, input tx_done);
    modport slave  (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/telemetry_sched_tmr.sv
// Free-running telemetry period counter.
//   clk, rst_n : clock, synchronous active-low reset (counter cleared to 0)
//   tick       : high for the one cycle the counter is all-ones
// Width is 12 bits with FAST_SIM=1, 20 bits otherwise; the counter wraps
// and never stalls.
module telem_period_tmr
    import eBike_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned W = FAST_SIM ? TELEM_PER_W_FAST : TELEM_PER_W;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == '1);

endmodule

// File: rtl/telemetry_sched.sv
// Periodic telemetry scheduler: on each period tick with en=1 it snapshots
// batt/curr/torque and sends an 8-byte framed packet through UART_tx.
//   clk, rst_n            : clock, synchronous active-low reset
//   en                    : telemetry enable, sampled on each tick
//   batt, curr, torque    : 12-bit values captured at packet start
//   uart (master)         : trmt/tx_data out, tx_done in
//   busy                  : packet in flight
//   pkt_done              : one-cycle pulse after the last byte's tx_done
//   ovr                   : sticky, set by a tick while busy; reset clears it
// All outputs are registered.
module telemetry_sched
    import eBike_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [11:0]              batt,
    input  logic [11:0]              curr,
    input  logic [11:0]              torque,
    telemetry_sched_if.master        uart,
    output logic                     busy,
    output logic                     pkt_done,
    output logic                     ovr
);

    localparam logic [2:0] LAST_IDX = 3'(TELEM_NBYTES - 1);

    logic tick;

    telem_period_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    telem_state_t state, state_n;
    logic [2:0]   idx, idx_n;
    logic [11:0]  batt_q, curr_q, torque_q;
    logic [11:0]  batt_n, curr_n, torque_n;
    logic         trmt_q, trmt_n;
    logic [7:0]   tx_data_q, tx_data_n;
    logic         busy_n, done_n, ovr_n;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        batt_n   = batt_q;
        curr_n   = curr_q;
        torque_n = torque_q;
        done_n   = 1'b0;
        ovr_n    = ovr;

        case (state)
            IDLE: begin
                if (tick && en) begin
                    batt_n   = batt;
                    curr_n   = curr;
                    torque_n = torque;
                    idx_n    = '0;
                    state_n  = LOAD;
                end
            end
            LOAD: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (uart.tx_done) begin
                    if (idx == LAST_IDX) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A tick outside IDLE is dropped and flagged; the packet carries on.
        if (tick && (state != IDLE)) begin
            ovr_n = 1'b1;
        end

        // Outputs are registered from next-state values so trmt/tx_data are
        // valid in the LOAD cycle itself; on packet start the byte is built
        // from the live inputs being snapshotted on the same edge.
        trmt_n    = (state_n == LOAD);
        tx_data_n = trmt_n ? telem_byte(idx_n, batt_n, curr_n, torque_n)
                           : tx_data_q;
        busy_n    = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            batt_q    <= '0;
            curr_q    <= '0;
            torque_q  <= '0;
            trmt_q    <= 1'b0;
            tx_data_q <= '0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            batt_q    <= batt_n;
            curr_q    <= curr_n;
            torque_q  <= torque_n;
            trmt_q    <= trmt_n;
            tx_data_q <= tx_data_n;
            busy      <= busy_n;
            pkt_done  <= done_n;
            ovr       <= ovr_n;
        end
    end

    assign uart.trmt    = trmt_q;
    assign uart.tx_data = tx_data_q;

endmodule

// File: tb/tb_telemetry_sched.sv
// Scoreboard bench for telemetry_sched (FAST_SIM=1, 4096-cycle period).
// Expected packet bytes are queued as stimulus is issued; a monitor pops one
// entry per trmt and compares tx_data. A UART stand-in answers each trmt
// with tx_done 10 cycles later.
module tb_telemetry_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] batt = '0;
    logic [11:0] curr = '0;
    logic [11:0] torque = '0;
    logic        busy, pkt_done, ovr;

    telemetry_sched_if uart_if ();

    telemetry_sched #(.FAST_SIM(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .batt     (batt),
        .curr     (curr),
        .torque   (torque),
        .uart     (uart_if),
        .busy     (busy),
        .pkt_done (pkt_done),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int          n_starts = 0;
    int          n_pkts = 0;
    int          n_trmt = 0;
    int          pos = 0;
    int unsigned last_start = 0;
    logic [7:0]  cur_byte = '0;

    bit hold_done = 1'b0;
    bit spur_req = 1'b0;
    int resp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [63:0] p);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data  = p[63-8*i -: 8];
            e.first = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (n_starts < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(n_starts >= n), 32'd1);
    endtask

    task automatic wait_pkts(input int n, input int budget, input string name);
        int k = 0;
        while (n_pkts < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(n_pkts >= n), 32'd1);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // UART stand-in: tx_done 10 cycles after each trmt, optionally withheld.
    initial begin
        uart_if.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            uart_if.tx_done = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
            end else if (spur_req) begin
                uart_if.tx_done = 1'b1;
                spur_req = 1'b0;
            end else if (uart_if.trmt === 1'b1) begin
                resp_cnt = 10;
            end else if (resp_cnt > 0) begin
                if (!(hold_done && resp_cnt == 1)) begin
                    resp_cnt--;
                    if (resp_cnt == 0) uart_if.tx_done = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every presented byte against the scoreboard.
    always @(negedge clk) begin
        if (uart_if.trmt === 1'b1) begin
            n_trmt++;
            cur_byte = uart_if.tx_data;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_trmt: got tx_data=%0h expected no byte", uart_if.tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_byte", 32'(uart_if.tx_data), 32'(mon_e.data));
                if (mon_e.first) begin
                    pos = 0;
                    n_starts++;
                    last_start = cyc;
                end
                pos++;
            end
        end
        if (uart_if.tx_done === 1'b1 && busy === 1'b1)
            check("tx_data_hold", 32'(uart_if.tx_data), 32'(cur_byte));
        if (pkt_done === 1'b1) begin
            n_pkts++;
            check("busy_low_at_pkt_done", 32'(busy), 32'd0);
        end
    end

    int unsigned rel, s1, s3, s5;
    int          trm0;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trmt", 32'(uart_if.trmt), 32'd0);
        check("rst_tx_data", 32'(uart_if.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);

        // Basic packet
        en = 1'b1;
        batt = 12'hB80;
        curr = 12'h123;
        torque = 12'h700;
        push_pkt(64'hAA55_0B80_0123_0700);
        rst_n = 1'b1;
        rel = cyc;
        wait_starts(1, 5000, "pkt1_start");
        s1 = last_start;
        check("first_trmt_latency", s1 - rel, 32'd4096);
        wait_pkts(1, 300, "pkt1_done");
        @(negedge clk);
        check("pkt1_busy_after", 32'(busy), 32'd0);
        check("pkt1_ovr", 32'(ovr), 32'd0);
        check("pkt1_count", 32'(n_pkts), 32'd1);

        // Snapshot: batt changes after byte 2 of packet 2
        push_pkt(64'hAA55_0B80_0123_0700);
        push_pkt(64'hAA55_0400_0123_0700);
        wait_starts(2, 5000, "pkt2_start");
        check("period_pkt2", last_start - s1, 32'd4096);
        wait_cyc(last_start + 25);
        batt = 12'h400;
        wait_pkts(2, 300, "pkt2_done");
        wait_starts(3, 5000, "pkt3_start");
        s3 = last_start;
        check("period_pkt3", s3 - s1, 32'd8192);
        wait_pkts(3, 300, "pkt3_done");

        // Disable across 3 ticks
        en = 1'b0;
        trm0 = n_trmt;
        wait_cyc(s3 + 3 * 4096 + 50);
        check("dis_no_trmt", 32'(n_trmt), 32'(trm0));
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_ovr", 32'(ovr), 32'd0);

        // Spurious tx_done in IDLE
        spur_req = 1'b1;
        repeat (6) @(negedge clk);
        check("spur_no_trmt", 32'(n_trmt), 32'(trm0));
        check("spur_busy", 32'(busy), 32'd0);
        curr = 12'h9C5;
        torque = 12'h03F;
        push_pkt(64'hAA55_0400_09C5_003F);
        en = 1'b1;
        wait_starts(4, 5000, "pkt4_start");
        check("restart_after_disable", last_start - s3, 32'd16384);
        wait_pkts(4, 300, "pkt4_done");

        // Overrun: withhold the first tx_done past the next tick
        hold_done = 1'b1;
        batt = 12'hFFF;
        curr = 12'h000;
        torque = 12'hA5A;
        push_pkt(64'hAA55_0FFF_0000_0A5A);
        wait_starts(5, 5000, "pkt5_start");
        s5 = last_start;
        wait_cyc(s5 + 4000);
        check("ovr_before_tick", 32'(ovr), 32'd0);
        check("busy_while_held", 32'(busy), 32'd1);
        wait_cyc(s5 + 4096 + 5);
        check("ovr_after_tick", 32'(ovr), 32'd1);
        check("busy_after_ovr_tick", 32'(busy), 32'd1);
        batt = 12'h321;
        curr = 12'h654;
        torque = 12'h987;
        hold_done = 1'b0;
        wait_pkts(5, 500, "pkt5_done");
        check("ovr_sticky", 32'(ovr), 32'd1);
        push_pkt(64'hAA55_0321_0654_0987);
        wait_starts(6, 9000, "pkt6_start");
        check("no_pkt_on_ovr_tick", last_start - s5, 32'd8192);

        // Reset during byte 4's WAIT
        begin
            int k = 0;
            while (pos < 5 && k < 300) begin
                @(negedge clk);
                k++;
            end
        end
        check("reached_byte4", 32'(pos), 32'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_trmt", 32'(uart_if.trmt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(uart_if.tx_data), 32'd0);
        check("midrst_ovr", 32'(ovr), 32'd0);
        check("midrst_pkt_done", 32'(pkt_done), 32'd0);
        push_pkt(64'hAA55_0321_0654_0987);
        rst_n = 1'b1;
        rel = cyc;
        wait_starts(7, 5000, "pkt7_start");
        check("post_rst_latency", last_start - rel, 32'd4096);
        wait_pkts(6, 300, "pkt7_done");
        @(negedge clk);
        check("final_pkt_count", 32'(n_pkts), 32'd6);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
